// File: rtl/fewcore_pkg.sv
// Shared core-wide constants and types for the front end.
package fewcore_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] data;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
    return a & ~XLEN'(3);
  endfunction
endpackage

// File: rtl/fetch_unit_if.sv
// Fetch stage bus: imem request/response, redirect from resolution, decoder handshake.
interface fetch_unit_if;
  import fewcore_pkg::*;

  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready;
  logic            imem_resp_valid;
  logic [XLEN-1:0] imem_resp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            inst_valid;
  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] inst_pc;
  logic            inst_ready;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
           redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
           redirect_valid, redirect_pc, inst_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; head is read straight from storage.
// Push into a full FIFO or pop from an empty one is ignored.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             push_dat_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             pop_dat_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_en, pop_en;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign pop_dat_o = mem_q[rd_ptr_q];
  assign push_en   = push_i && !full_o;
  assign pop_en    = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(push_en) - CW'(pop_en);
    if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= push_dat_i;
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, credit-limited imem requests, prefetch queue to decoder.
// Redirect flushes the queue and drops every response still in flight.
module fetch_unit
  import fewcore_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int              DEPTH    = 4
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = $bits(fetch_entry_t);

  logic            rst_q;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   outst_q, outst_d, disc_q, disc_d;
  logic [CW-1:0]   occ, sh_count;
  logic [CW:0]     credit_used;
  logic            accept, resp_eff, push, pop;
  logic            q_empty, q_full, sh_empty, sh_full;
  fetch_entry_t    q_head, q_in;
  logic [XLEN-1:0] sh_head;
  logic            unused_status;

  // Queued entries plus in-flight requests may never exceed the queue size.
  assign credit_used        = {1'b0, occ} + {1'b0, outst_q};
  assign bus.imem_req_valid = !rst_q && (credit_used < (CW+1)'(DEPTH));
  assign bus.imem_req_addr  = pc_q;

  assign accept   = bus.imem_req_valid && bus.imem_req_ready;
  assign resp_eff = bus.imem_resp_valid && (outst_q != '0);
  assign push     = resp_eff && (disc_q == '0) && !bus.redirect_valid;
  assign pop      = bus.inst_valid && bus.inst_ready && !bus.redirect_valid;

  assign q_in = '{pc: sh_head, data: bus.imem_resp_data};

  assign bus.inst_valid = !q_empty;
  assign bus.inst       = q_empty ? INST_NOP : q_head.data;
  assign bus.inst_pc    = q_empty ? '0 : q_head.pc;

  always_comb begin
    pc_d    = pc_q;
    outst_d = outst_q + CW'(accept) - CW'(resp_eff);
    disc_d  = disc_q;
    if (accept) pc_d = pc_q + XLEN'(4);
    if (resp_eff && (disc_q != '0)) disc_d = disc_q - 1'b1;
    // Everything still in flight after this cycle belongs to the old stream.
    if (bus.redirect_valid) begin
      pc_d   = align_word(bus.redirect_pc);
      disc_d = outst_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rst_q   <= 1'b1;
      pc_q    <= align_word(RESET_PC);
      outst_q <= '0;
      disc_q  <= '0;
    end else begin
      rst_q   <= 1'b0;
      pc_q    <= pc_d;
      outst_q <= outst_d;
      disc_q  <= disc_d;
    end
  end

  fetch_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_inst_q (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (bus.redirect_valid),
    .push_i     (push),
    .push_dat_i (q_in),
    .pop_i      (pop),
    .pop_dat_o  (q_head),
    .full_o     (q_full),
    .empty_o    (q_empty),
    .count_o    (occ)
  );

  // Never flushed: discarded responses must still retire their request PC.
  fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_pc_shadow (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (1'b0),
    .push_i     (accept),
    .push_dat_i (pc_q),
    .pop_i      (resp_eff),
    .pop_dat_o  (sh_head),
    .full_o     (sh_full),
    .empty_o    (sh_empty),
    .count_o    (sh_count)
  );

  assign unused_status = ^{q_full, sh_full, sh_empty, sh_count};
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order imem model, stream scoreboard, directed corners, random run.
module tb_fetch_unit;
  import fewcore_pkg::*;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          due;
    logic [31:0] addr;
    int          epoch;
  } mreq_t;

  typedef struct {
    logic [31:0] rpc;
    logic [31:0] exp_addr;
    logic [31:0] exp_next;
  } vec_t;

  mreq_t       memq[$];
  int          tests = 0, fails = 0, cyc = 0, epoch = 0, last_due = 0, model_buf = 0;
  int          lat_min = 1, lat_max = 1, n_consumed = 0, n_accepted = 0;
  logic [31:0] exp_req_addr = RST_PC, exp_inst_pc = RST_PC, last_cons_pc = '0;
  logic        model_rstq = 1'b1;
  logic        d_req_ready = 0, d_inst_ready = 0, d_redirect = 0, d_rst = 1;
  logic [31:0] d_rpc = '0;
  logic        last_accept = 0, last_resp = 0;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: check outputs against the model, drive this cycle's inputs, advance.
  task automatic cycle();
    mreq_t m;
    logic  resp, kept, acc, cons;
    int    due;
    check("req_valid", 32'(bus.imem_req_valid),
          32'(!model_rstq && (memq.size() + model_buf < DEPTH)));
    check("inst_valid", 32'(bus.inst_valid), 32'(model_buf > 0));
    if (!bus.inst_valid) begin
      check("idle_inst", bus.inst, INST_NOP);
      check("idle_pc", bus.inst_pc, 32'h0);
    end
    resp = 1'b0;
    kept = 1'b0;
    if (!d_rst && memq.size() > 0 && memq[0].due <= cyc) begin
      m = memq.pop_front();
      resp = 1'b1;
      kept = (m.epoch == epoch) && !d_redirect;
      bus.imem_resp_data = data_of(m.addr);
    end else begin
      bus.imem_resp_data = $urandom;
    end
    bus.imem_resp_valid = resp;
    acc = bus.imem_req_valid && d_req_ready && !d_rst;
    if (acc) begin
      check("req_addr", bus.imem_req_addr, exp_req_addr);
      due = cyc + $urandom_range(lat_max, lat_min);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      memq.push_back('{due, exp_req_addr, epoch});
      exp_req_addr += 32'd4;
      n_accepted++;
    end
    cons = bus.inst_valid && d_inst_ready && !d_redirect && !d_rst;
    if (cons) begin
      check("inst_pc", bus.inst_pc, exp_inst_pc);
      check("inst", bus.inst, data_of(exp_inst_pc));
      last_cons_pc = bus.inst_pc;
      exp_inst_pc += 32'd4;
      if (model_buf > 0) model_buf--;
      n_consumed++;
    end
    if (kept) model_buf++;
    if (d_redirect) begin
      epoch++;
      model_buf    = 0;
      exp_req_addr = d_rpc & ~32'h3;
      exp_inst_pc  = d_rpc & ~32'h3;
    end
    if (d_rst) begin
      memq.delete();
      model_buf    = 0;
      epoch++;
      last_due     = cyc;
      exp_req_addr = RST_PC;
      exp_inst_pc  = RST_PC;
    end
    last_accept = acc;
    last_resp   = resp;
    model_rstq  = d_rst;
    bus.imem_req_ready = d_req_ready;
    bus.inst_ready     = d_inst_ready;
    bus.redirect_valid = d_redirect;
    bus.redirect_pc    = d_rpc;
    rst                = d_rst;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    d_rst = 1'b1; d_redirect = 1'b0; d_req_ready = 1'b0; d_inst_ready = 1'b0;
    lat_min = 1; lat_max = 1;
    repeat (2) cycle();
    d_rst = 1'b0;
  endtask

  vec_t vecs[5];

  initial begin
    int a0, c0, w;
    vecs[0] = '{32'h0000_0203, 32'h0000_0200, 32'h0000_0204};
    vecs[1] = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000};
    vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0000_0000};
    vecs[3] = '{32'h0000_0001, 32'h0000_0000, 32'h0000_0004};
    vecs[4] = '{32'h8000_1236, 32'h8000_1234, 32'h8000_1238};

    rst = 1'b1;
    bus.imem_req_ready = 0; bus.imem_resp_valid = 0; bus.imem_resp_data = '0;
    bus.redirect_valid = 0; bus.redirect_pc = '0; bus.inst_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_valid", 32'(bus.imem_req_valid), 32'h0);
    check("rst_inst_valid", 32'(bus.inst_valid), 32'h0);
    check("rst_inst", bus.inst, INST_NOP);
    check("rst_inst_pc", bus.inst_pc, 32'h0);

    // Streaming: latency 1, everything ready.
    do_reset();
    d_req_ready = 1; d_inst_ready = 1;
    cycle();
    check("first_req_valid", 32'(bus.imem_req_valid), 32'h1);
    check("first_req_addr", bus.imem_req_addr, RST_PC);
    cycle(); cycle();
    check("first_inst_valid", 32'(bus.inst_valid), 32'h1);
    check("first_inst_pc", bus.inst_pc, RST_PC);
    c0 = n_consumed;
    repeat (8) cycle();
    check("throughput", 32'(n_consumed - c0), 32'd8);

    // Decoder stalled: credits run out at DEPTH, one pop frees one request.
    do_reset();
    d_req_ready = 1; d_inst_ready = 0;
    a0 = n_accepted;
    repeat (10) cycle();
    check("stall_accepts", 32'(n_accepted - a0), 32'(DEPTH));
    check("stall_req_valid", 32'(bus.imem_req_valid), 32'h0);
    d_inst_ready = 1; cycle(); d_inst_ready = 0;
    check("resume_req_valid", 32'(bus.imem_req_valid), 32'h1);
    cycle();
    check("resume_accepts", 32'(n_accepted - a0), 32'(DEPTH + 1));
    check("restall_req_valid", 32'(bus.imem_req_valid), 32'h0);

    // Latency 3, redirect with two requests in flight.
    do_reset();
    lat_min = 3; lat_max = 3;
    d_req_ready = 1; d_inst_ready = 1;
    cycle(); cycle(); cycle();
    d_req_ready = 0; d_redirect = 1; d_rpc = 32'h0000_0100;
    cycle();
    d_redirect = 0; d_req_ready = 1; d_inst_ready = 0;
    check("redir_inst_valid", 32'(bus.inst_valid), 32'h0);
    check("redir_req_addr", bus.imem_req_addr, 32'h0000_0100);
    w = 0;
    while (!bus.inst_valid && w < 20) begin cycle(); w++; end
    check("redir_latency", 32'(w), 32'd4);
    check("redir_target_pc", bus.inst_pc, 32'h0000_0100);

    // Redirect in the same cycle as an accept and a response.
    do_reset();
    d_req_ready = 1; d_inst_ready = 1;
    repeat (6) cycle();
    d_redirect = 1; d_rpc = 32'h0000_0040;
    cycle();
    d_redirect = 0;
    check("corner_accept", 32'(last_accept), 32'h1);
    check("corner_resp", 32'(last_resp), 32'h1);
    check("corner_inst_valid", 32'(bus.inst_valid), 32'h0);
    c0 = n_consumed; w = 0;
    while (n_consumed == c0 && w < 20) begin cycle(); w++; end
    check("corner_first_pc", last_cons_pc, 32'h0000_0040);

    // Redirect alignment and PC wrap, table driven.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      d_req_ready = 0; d_inst_ready = 1; d_redirect = 1; d_rpc = vecs[i].rpc;
      cycle();
      d_redirect = 0;
      check("vec_addr", bus.imem_req_addr, vecs[i].exp_addr);
      d_req_ready = 1;
      cycle();
      d_req_ready = 0;
      check("vec_next_addr", bus.imem_req_addr, vecs[i].exp_next);
      repeat (3) cycle();
    end

    // Reset in mid-stream with three queued entries.
    do_reset();
    d_req_ready = 1; d_inst_ready = 0;
    w = 0;
    while (model_buf < 3 && w < 20) begin cycle(); w++; end
    check("pre_rst_inst_valid", 32'(bus.inst_valid), 32'h1);
    d_rst = 1;
    cycle();
    check("mid_rst_req_valid", 32'(bus.imem_req_valid), 32'h0);
    check("mid_rst_inst_valid", 32'(bus.inst_valid), 32'h0);
    check("mid_rst_inst", bus.inst, INST_NOP);
    check("mid_rst_inst_pc", bus.inst_pc, 32'h0);
    d_rst = 0; d_inst_ready = 1;
    cycle();
    check("post_rst_req_valid", 32'(bus.imem_req_valid), 32'h1);
    check("post_rst_req_addr", bus.imem_req_addr, RST_PC);
    c0 = n_consumed; w = 0;
    while (n_consumed == c0 && w < 20) begin cycle(); w++; end
    check("post_rst_first_pc", last_cons_pc, RST_PC);

    // Random traffic against the stream scoreboard.
    do_reset();
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      d_req_ready  = ($urandom_range(3, 0) != 0);
      d_inst_ready = ($urandom_range(3, 0) != 0);
      d_redirect   = ($urandom_range(31, 0) == 0);
      d_rpc        = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFE0 | 32'($urandom_range(31, 0)))
                                                 : $urandom;
      d_rst        = ($urandom_range(499, 0) == 0);
      cycle();
    end
    d_rst = 0; d_redirect = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
